// File: rtl/morse_letter_scheduler.sv
// Two-port Morse letter scheduler: round-robin request/acknowledge into a 4-deep FIFO,
// drained by one bit-serial playback engine that appends a fixed inter-letter gap.
module morse_letter_scheduler #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned GAP_BITS        = 3
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic [2:0] LetterA,
  input  logic [2:0] LetterB,
  output logic       AckA,
  output logic       AckB,
  output logic       DotDashOut,
  output logic       NewBitOut,
  output logic       Busy,
  output logic [2:0] QueueCount
);

  localparam int unsigned BitTicks = CLOCK_FREQUENCY / 2;
  localparam int unsigned TickW    = $clog2(BitTicks);
  localparam int unsigned GapW     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(BitTicks - 1);
  localparam logic [GapW-1:0]  GapMax  = GapW'(GAP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [3:0]        bit_q, bit_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [11:0]       shift_q, shift_d;
  logic [2:0]        mem_q [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        count_q;
  logic              ptr_q, ptr_d;  // 0 = A has priority on a tie
  logic              ack_a_q, ack_b_q;
  logic              elig_a, elig_b, grant_a, grant_b;
  logic              push, pop, tick_done;
  logic [2:0]        push_letter;

  function automatic logic [11:0] rom_code(input logic [2:0] code);
    case (code)
      3'd0:    rom_code = 12'hB80;
      3'd1:    rom_code = 12'hEA8;
      3'd2:    rom_code = 12'hEB8;
      3'd3:    rom_code = 12'hEA0;
      3'd4:    rom_code = 12'hA00;
      3'd5:    rom_code = 12'hAB8;
      3'd6:    rom_code = 12'hEE0;
      default: rom_code = 12'hAA8;
    endcase
  endfunction

  // A port whose Ack is high is ineligible so one Req can never be accepted twice in a row.
  always_comb begin
    elig_a  = ReqA & ~ack_a_q;
    elig_b  = ReqB & ~ack_b_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    ptr_d   = ptr_q;
    if (count_q != 3'd4) begin
      if (elig_a && (!elig_b || !ptr_q)) begin
        grant_a = 1'b1;
        ptr_d   = 1'b1;
      end else if (elig_b) begin
        grant_b = 1'b1;
        ptr_d   = 1'b0;
      end
    end
    push        = grant_a | grant_b;
    push_letter = grant_a ? LetterA : LetterB;
  end

  assign tick_done = (tick_q == TickMax);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = rom_code(mem_q[rd_ptr_q]);
          bit_d   = 4'd0;
          tick_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        tick_d = tick_done ? '0 : tick_q + TickW'(1);
        if (tick_done) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd11) begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        tick_d = tick_done ? '0 : tick_q + TickW'(1);
        if (tick_done) begin
          gap_d = gap_q + GapW'(1);
          if (gap_q == GapMax) begin
            // Back-to-back: a waiting letter starts without passing through idle.
            if (count_q != 3'd0) begin
              pop     = 1'b1;
              shift_d = rom_code(mem_q[rd_ptr_q]);
              bit_d   = 4'd0;
              state_d = StSend;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ptr_q    <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_q + {1'b0, push};
      rd_ptr_q <= rd_ptr_q + {1'b0, pop};
      count_q  <= count_q + {2'b00, push} - {2'b00, pop};
      ptr_q    <= ptr_d;
      ack_a_q  <= grant_a;
      ack_b_q  <= grant_b;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_letter;
    end
  end

  assign AckA       = ack_a_q;
  assign AckB       = ack_b_q;
  assign Busy       = (state_q != StIdle);
  assign NewBitOut  = (state_q != StIdle) && (tick_q == '0);
  assign DotDashOut = (state_q == StSend) && shift_q[11];
  assign QueueCount = count_q;

endmodule

// File: tb/tb_morse_letter_scheduler.sv
// Bench for morse_letter_scheduler: a letter-level timeline model predicts acks, occupancy and
// the bit stream; a scoreboard queue of expected bits is drained by a NewBitOut monitor.
module tb_morse_letter_scheduler;

  localparam int BT  = 4;
  localparam int GB  = 3;
  localparam int LEN = (12 + GB) * BT;

  logic       ClockIn = 1'b0;
  logic       Reset   = 1'b1;
  logic       ReqA    = 1'b0;
  logic       ReqB    = 1'b0;
  logic [2:0] LetterA = 3'd0;
  logic [2:0] LetterB = 3'd0;
  logic       AckA, AckB, DotDashOut, NewBitOut, Busy;
  logic [2:0] QueueCount;

  morse_letter_scheduler #(
    .CLOCK_FREQUENCY(8),
    .GAP_BITS(GB)
  ) dut (
    .ClockIn(ClockIn),
    .Reset(Reset),
    .ReqA(ReqA),
    .ReqB(ReqB),
    .LetterA(LetterA),
    .LetterB(LetterB),
    .AckA(AckA),
    .AckB(AckB),
    .DotDashOut(DotDashOut),
    .NewBitOut(NewBitOut),
    .Busy(Busy),
    .QueueCount(QueueCount)
  );

  always #5 ClockIn = ~ClockIn;

  logic [11:0] rom [8] = '{12'hB80, 12'hEA8, 12'hEB8, 12'hEA0,
                           12'hA00, 12'hAB8, 12'hEE0, 12'hAA8};

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int nb_count = 0;
  int ackb_cnt = 0;
  int mode_a   = 0;  // 0 drop on ack, 1 hold and re-present, 2 random, 3 manual
  int mode_b   = 0;

  // Letter timeline: push edge, pop edge and code of every accepted letter since reset.
  int l_push[$];
  int l_pop[$];
  int l_code[$];
  logic sb[$];
  logic eack_a = 1'b0, eack_b = 1'b0, rr = 1'b0;
  int exp_busy = 0, exp_qc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge();
    int occ;
    logic ea, eb, ga, gb;
    logic [14:0] pat;
    int code, pop_e;
    edge_n++;
    if (Reset) begin
      l_push.delete();
      l_pop.delete();
      l_code.delete();
      sb.delete();
      eack_a = 1'b0;
      eack_b = 1'b0;
      rr     = 1'b0;
      return;
    end
    occ = 0;
    foreach (l_push[i]) if (l_push[i] < edge_n && l_pop[i] >= edge_n) occ++;
    ea = ReqA && !eack_a;
    eb = ReqB && !eack_b;
    ga = 1'b0;
    gb = 1'b0;
    if (occ < 4) begin
      if (ea && (!eb || rr == 1'b0)) begin
        ga = 1'b1;
        rr = 1'b1;
      end else if (eb) begin
        gb = 1'b1;
        rr = 1'b0;
      end
    end
    eack_a = ga;
    eack_b = gb;
    if (ga || gb) begin
      code  = ga ? int'(LetterA) : int'(LetterB);
      pop_e = edge_n + 1;
      if (l_pop.size() > 0 && l_pop[l_pop.size()-1] + LEN > pop_e)
        pop_e = l_pop[l_pop.size()-1] + LEN;
      l_push.push_back(edge_n);
      l_pop.push_back(pop_e);
      l_code.push_back(code);
      pat = {rom[code], 3'b000};
      for (int i = 14; i >= 0; i--) sb.push_back(pat[i]);
    end
  endtask

  task automatic check_cycle();
    int lp, lc, off;
    logic [14:0] pat;
    int e_nb, e_dd;
    lp = -1;
    lc = 0;
    exp_qc = 0;
    foreach (l_push[i]) begin
      if (l_push[i] <= edge_n && l_pop[i] > edge_n) exp_qc++;
      if (l_pop[i] <= edge_n) begin
        lp = l_pop[i];
        lc = l_code[i];
      end
    end
    exp_busy = (lp >= 0 && edge_n < lp + LEN) ? 1 : 0;
    e_nb = 0;
    e_dd = 0;
    if (exp_busy != 0) begin
      off  = edge_n - lp;
      pat  = {rom[lc], 3'b000};
      e_nb = (off % BT == 0) ? 1 : 0;
      e_dd = int'(pat[14 - off / BT]);
    end
    chk("ack_a", int'(AckA), int'(eack_a));
    chk("ack_b", int'(AckB), int'(eack_b));
    chk("queue_count", int'(QueueCount), exp_qc);
    chk("busy", int'(Busy), exp_busy);
    chk("new_bit", int'(NewBitOut), e_nb);
    chk("dot_dash", int'(DotDashOut), e_dd);
    if (AckB === 1'b1) ackb_cnt++;
  endtask

  task automatic drive_ports();
    if (eack_a && mode_a == 1) LetterA = 3'($urandom_range(0, 7));
    else if (eack_a && mode_a != 3) ReqA = 1'b0;
    if (eack_b && mode_b == 1) LetterB = 3'($urandom_range(0, 7));
    else if (eack_b && mode_b != 3) ReqB = 1'b0;
    if (mode_a == 2 && !ReqA && !eack_a && $urandom_range(0, 3) == 0) begin
      ReqA    = 1'b1;
      LetterA = 3'($urandom_range(0, 7));
    end
    if (mode_b == 2 && !ReqB && !eack_b && $urandom_range(0, 3) == 0) begin
      ReqB    = 1'b1;
      LetterB = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic step();
    @(posedge ClockIn);
    model_edge();
    @(negedge ClockIn);
    check_cycle();
    drive_ports();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int budget;
    mode_a = 0;
    mode_b = 0;
    ReqA   = 1'b0;
    ReqB   = 1'b0;
    budget = 0;
    step();
    while ((exp_busy != 0 || exp_qc != 0) && budget < 600) begin
      step();
      budget++;
    end
    chk("drain_timeout", budget < 600 ? 1 : 0, 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  // Monitor: every NewBitOut pulse consumes one expected bit from the scoreboard.
  always @(negedge ClockIn) begin
    if (NewBitOut === 1'b1) begin
      nb_count++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_bit at cycle %0d: got NewBitOut=1, expected no bit", edge_n);
      end else begin
        logic e;
        e = sb.pop_front();
        if (DotDashOut !== e) begin
          n_fail++;
          $display("FAIL sb_bit at cycle %0d: got %0d, expected %0d", edge_n, DotDashOut, e);
        end
      end
    end
  end

  initial begin
    int base, budget;
    steps(2);
    Reset = 1'b0;
    steps(3);

    // Single letter on A.
    nb_count = 0;
    ReqA = 1'b1;
    LetterA = 3'd0;
    steps(70);
    chk("single_new_bits", nb_count, 15);

    // Simultaneous requests, A wins first, back-to-back playback.
    nb_count = 0;
    ReqA = 1'b1;
    LetterA = 3'd4;
    ReqB = 1'b1;
    LetterB = 3'd7;
    steps(130);
    chk("simul_new_bits", nb_count, 30);

    // Fairness with both requests held permanently; FIFO fills and stalls.
    mode_a = 1;
    mode_b = 1;
    ReqA = 1'b1;
    LetterA = 3'($urandom_range(0, 7));
    ReqB = 1'b1;
    LetterB = 3'($urandom_range(0, 7));
    steps(400);
    drain();

    // Held request on B for three edges.
    mode_b = 3;
    ackb_cnt = 0;
    ReqB = 1'b1;
    LetterB = 3'd6;
    steps(3);
    ReqB = 1'b0;
    steps(2);
    chk("held_acks", ackb_cnt, 2);
    drain();

    // Reset during bit 5 of EB8 with two letters queued.
    base = l_pop.size();
    ReqA = 1'b1;
    LetterA = 3'd2;
    budget = 0;
    while (l_pop.size() == base && budget < 20) begin
      step();
      budget++;
    end
    ReqA = 1'b1;
    LetterA = 3'd3;
    ReqB = 1'b1;
    LetterB = 3'd5;
    budget = 0;
    while (l_pop.size() > base && edge_n < l_pop[base] + 5 * BT + 1 && budget < 200) begin
      step();
      budget++;
    end
    chk("reset_queue_before", exp_qc, 2);
    Reset = 1'b1;
    step();
    chk("reset_busy", int'(Busy), 0);
    chk("reset_qc", int'(QueueCount), 0);
    Reset = 1'b0;
    ReqA = 1'b0;
    ReqB = 1'b0;
    steps(20);
    chk("after_reset_busy", int'(Busy), 0);

    // Random traffic with well-behaved requesters.
    mode_a = 2;
    mode_b = 2;
    steps(1500);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_letter_scheduler.md
# morse_letter_scheduler

Shares one Morse playback engine between two letter requesters (A and B). Accepted letters go into a 4-entry FIFO, and each letter plays as a 12-bit dot/dash pattern (MSB first, one bit per half second), followed by a fixed inter-letter gap. The block sits between the board-level letter sources (switch/key front ends) and the LEDR dot/dash output. It replaces ad-hoc Start pulsing with a proper request/acknowledge scheduler.

## Interface
- CLOCK_FREQUENCY, 50000000, ClockIn frequency in Hz; bit period BIT_TICKS = CLOCK_FREQUENCY/2 cycles (must be ≥ 2)
- GAP_BITS, 3, number of zero bit periods appended after every letter (≥ 1)
- ClockIn  in  1  clock
- Reset  in  1  reset Reset, synchronous, active-high; clock ClockIn
- ReqA / ReqB  in  1  letter request from requester A / B; held until acknowledged
- LetterA / LetterB  in  3  letter code, stable while the matching Req is high
- AckA / AckB  out  1  one-cycle pulse: the letter was written into the FIFO
- DotDashOut  out  1  current Morse bit (1 = lit)
- NewBitOut  out  1  one-cycle pulse in the first cycle of every bit period, gap bits included
- Busy  out  1  engine not IDLE
- QueueCount  out  3  FIFO occupancy, 0..4

## Operation
- Code ROM, 12 bits, MSB sent first:
  - 0 → B80, 1 → EA8, 2 → EB8, 3 → EA0
  - 4 → A00, 5 → AB8, 6 → EE0, 7 → AA8
- Acceptance, evaluated at each edge using pre-edge state:
  - Port X is eligible when ReqX=1 and AckX=0. A port is ineligible while its Ack is high, which prevents double accept.
  - If QueueCount=4, nothing is accepted, even when a pop happens on the same edge.
  - At most one acceptance per edge.
  - If only one port is eligible, it wins.
  - If both are eligible, the port named by the round-robin pointer wins, and the pointer moves to the other port.
  - A grant to a single eligible port also sets the pointer to the other port.
  - The pointer resets to A.
- On acceptance: push the winner's letter code into the FIFO tail, and AckX=1 for exactly the next cycle. The requester drops Req on seeing Ack. If Req stays high, it is treated as a new request once Ack falls.
- Engine FSM states: IDLE, SEND, GAP.
  - IDLE: if QueueCount>0 at an edge, pop the head, load the shift register with its ROM code, set bit index = 0 and tick counter = 0, and go to SEND.
  - SEND: DotDashOut = shift register MSB. The tick counter counts 0..BIT_TICKS-1. At terminal count: counter ← 0, shift left, bit index +1. The terminal count of bit 11 goes to GAP with gap index = 0.
  - GAP: DotDashOut = 0, with the same tick/NewBitOut behaviour. At the terminal count of gap bit GAP_BITS-1:
    - FIFO non-empty: pop and go directly to SEND (back-to-back, no IDLE cycle).
    - FIFO empty: go to IDLE.
- NewBitOut = 1 exactly when state ∈ {SEND, GAP} and the tick counter is 0.
- Push and pop on the same edge: QueueCount unchanged, FIFO order preserved.
- Input letters are never dropped: a full FIFO stalls requesters by withholding Ack.

## Timing
- Reset values:
  - AckA = AckB = 0, DotDashOut = 0, NewBitOut = 0, Busy = 0, QueueCount = 0.
  - FIFO empty, state IDLE, pointer A, counters 0.
- Reset mid-letter or mid-gap: abort. Outputs return to reset values in the cycle after the Reset edge, queued letters are discarded, and any pending Ack is suppressed.
- Latency, where cycle k is the cycle following edge k:
  - Req sampled at edge k with the FIFO empty and the engine in IDLE gives AckX=1 and QueueCount=1 in cycle k.
  - The pop happens at edge k+1.
  - Cycle k+1 has Busy=1, NewBitOut=1, DotDashOut = code bit 11, and QueueCount=0.
- Letter duration is (12+GAP_BITS)·BIT_TICKS cycles. Each bit period is exactly BIT_TICKS cycles.
- NewBitOut pulses per letter: 12+GAP_BITS, each exactly one cycle wide.
- All outputs are registered or decoded from registered state only. There are no combinational paths from Req/Letter to outputs.

## Test plan
All scenarios use CLOCK_FREQUENCY=8 (BIT_TICKS=4) and GAP_BITS=3.
- Single letter: ReqA with LetterA=0.
  - AckA pulses for 1 cycle. One cycle later NewBitOut=1 and DotDashOut=1.
  - DotDashOut follows 1011_1000_0000 then 000, each bit 4 cycles, for 60 cycles total.
  - Busy then drops, and 15 NewBitOut pulses are observed.
- Simultaneous requests: ReqA(LetterA=4) and ReqB(LetterB=7) rise together.
  - AckA comes first, then AckB on the next eligible edge.
  - Playback is A00 then AA8 back-to-back (no IDLE cycle between), with Busy continuous for 120 cycles.
- Fairness: hold both Req high permanently while re-presenting letters after each Ack.
  - Acks strictly alternate A,B,A,B until the FIFO is full.
  - QueueCount reaches 4 and Acks stop.
  - The next Ack occurs only after a pop.
- Full FIFO: fill with 4 letters while the engine holds letter #1 (after its pop, QueueCount=3), then request twice more.
  - One request is accepted (QueueCount=4). The other Req waits, with no Ack, until the next pop edge plus one.
  - No letter is lost or reordered.
- Reset mid-playback: assert Reset during bit 5 of EB8 with 2 letters queued.
  - In the next cycle all outputs are 0 and QueueCount=0.
  - After release with no requests, Busy stays 0.
- Held request: keep ReqB=1 with LetterB=6 for 3 cycles.
  - AckB shows a one-cycle pulse, and the same letter is accepted at most twice (once initially and once after Ack falls), matching the handshake rule.
